// File: rtl/compare_result_monitor.sv
// Counts gt/eq/lt results from a magnitude comparator, tracks the current run of
// consecutive equal results against a threshold, and latches malformed flag sets.
module compare_result_monitor #(
  parameter int COUNT_WIDTH = 16,
  parameter int RUN_WIDTH   = 8
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Enable_In,
  input  logic                   Valid_In,
  input  logic                   A_gt_B_In,
  input  logic                   A_eq_B_In,
  input  logic                   A_lt_B_In,
  input  logic                   Clear_In,
  input  logic [RUN_WIDTH-1:0]   Run_Length_In,
  output logic [COUNT_WIDTH-1:0] Gt_Count_Out,
  output logic [COUNT_WIDTH-1:0] Eq_Count_Out,
  output logic [COUNT_WIDTH-1:0] Lt_Count_Out,
  output logic [RUN_WIDTH-1:0]   Eq_Run_Out,
  output logic                   Match_Out,
  output logic                   Error_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    MATCH = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [RUN_WIDTH-1:0]            run_q, run_d, run_inc;
  logic                            match_q, error_q;
  logic [2:0]                      flags;
  logic                            legal, accept, take_sample;
  logic [2:0][COUNT_WIDTH-1:0]     cnt_vec;

  // Bit 2 = gt, bit 1 = eq, bit 0 = lt; the counter generate loop uses the same order.
  assign flags = {A_gt_B_In, A_eq_B_In, A_lt_B_In};

  // Only the three one-hot patterns match; X/Z or multi-hot fall to default.
  always_comb begin
    legal = 1'b0;
    case (flags)
      3'b100, 3'b010, 3'b001: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  assign accept      = Valid_In && Enable_In && !Clear_In && (state_q != FAULT);
  assign take_sample = accept && legal;
  assign run_inc     = (run_q == '1) ? run_q : run_q + 1'b1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (Clear_In) begin
        cnt_d = '0;
      end else if (take_sample && flags[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_vec[gi] = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (Clear_In) begin
      state_d = IDLE;
      run_d   = '0;
    end else if (accept) begin
      if (!legal) begin
        state_d = FAULT;
      end else if (A_eq_B_In) begin
        run_d = run_inc;
        // Threshold is only consulted here, so a changed Run_Length_In never
        // moves the state on its own.
        if ((Run_Length_In != '0) && (run_inc >= Run_Length_In)) begin
          state_d = MATCH;
        end else if (state_q != MATCH) begin
          state_d = TRACK;
        end
      end else begin
        run_d   = '0;
        state_d = TRACK;
      end
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      run_q   <= '0;
      match_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      match_q <= (state_d == MATCH);
      error_q <= (state_d == FAULT);
    end
  end

  assign Gt_Count_Out = cnt_vec[2];
  assign Eq_Count_Out = cnt_vec[1];
  assign Lt_Count_Out = cnt_vec[0];
  assign Eq_Run_Out   = run_q;
  assign Match_Out    = match_q;
  assign Error_Out    = error_q;

endmodule
